// File: rtl/dotp_sequencer_if.sv
// ---------------------------------------------------------------------------
// dotp_sequencer_if
// Bundles the job-control, datapath-handshake and status signals of the
// dot-product sequencer.
//   master : the side that launches jobs and runs the datapath phases
//            (drives go/abort/vec_len/base_*/ *_done, observes strobes/status)
//   slave  : the sequencer itself
// Parameter LEN_W : width of vec_len and elem_idx.
// ---------------------------------------------------------------------------
interface dotp_sequencer_if #(
    parameter int LEN_W = 8
) ();
    // job control
    logic             go;
    logic             abort;
    logic [LEN_W-1:0] vec_len;
    logic [31:0]      base_a;
    logic [31:0]      base_b;
    logic [31:0]      base_out;

    // datapath phase-complete indications
    logic             fetch_done;
    logic             processing_done;
    logic             store_done;
    logic             read_done;

    // phase strobes and addresses
    logic             start_fetch;
    logic             start_compute;
    logic             start_write;
    logic             start_read;
    logic [31:0]      waddr_a;
    logic [31:0]      waddr_b;
    logic [31:0]      waddr_output;
    logic [LEN_W-1:0] elem_idx;

    // status
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output go, abort, vec_len, base_a, base_b, base_out,
        output fetch_done, processing_done, store_done, read_done,
        input  start_fetch, start_compute, start_write, start_read,
        input  waddr_a, waddr_b, waddr_output, elem_idx,
        input  busy, done, error
    );

    modport slave (
        input  go, abort, vec_len, base_a, base_b, base_out,
        input  fetch_done, processing_done, store_done, read_done,
        output start_fetch, start_compute, start_write, start_read,
        output waddr_a, waddr_b, waddr_output, elem_idx,
        output busy, done, error
    );
endinterface

// File: rtl/dotp_sequencer.sv
// ---------------------------------------------------------------------------
// dotp_sequencer
// Control FSM for a dot-product job: fetches vec_len element pairs one at a
// time, then issues a single compute, write and read phase, each phase being
// a one-cycle strobe followed by a wait for the matching *_done input.
// Every WAIT state is guarded by a timeout that ends the job in ERR.
//
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : dotp_sequencer_if.slave
//          in  : go, abort, vec_len, base_a/b/out, fetch/processing/store/read_done
//          out : start_fetch/compute/write/read, waddr_a/b/output, elem_idx,
//                busy, done (pulse), error (sticky)
// Parameters
//   LEN_W   : width of vec_len / elem_idx
//   TIMEOUT : maximum cycles spent in a WAIT state before ERR
// ---------------------------------------------------------------------------
module dotp_sequencer #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    dotp_sequencer_if.slave bus
);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Last WAIT cycle index: the counter is 0 on the first WAIT cycle, so ERR
    // follows exactly TIMEOUT cycles after WAIT entry.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH_REQ  = 4'd1,
        FETCH_WAIT = 4'd2,
        COMP_REQ   = 4'd3,
        COMP_WAIT  = 4'd4,
        WR_REQ     = 4'd5,
        WR_WAIT    = 4'd6,
        RD_REQ     = 4'd7,
        RD_WAIT    = 4'd8,
        DONE       = 4'd9,
        ERR        = 4'd10
    } state_t;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [31:0]      base_a_reg, base_a_next;
    logic [31:0]      base_b_reg, base_b_next;
    logic [31:0]      base_out_reg, base_out_next;
    logic [LEN_W-1:0] elem_idx_reg, elem_idx_next;
    logic [CNT_W-1:0] tmo_reg, tmo_next;
    logic             error_reg, error_next;

    // registered outputs
    logic             start_fetch_reg, start_compute_reg, start_write_reg, start_read_reg;
    logic             busy_reg, done_reg;
    logic [31:0]      waddr_a_reg, waddr_b_reg, waddr_output_reg;

    // per-WAIT-state view of the awaited done input and where it leads
    logic             wait_done;
    state_t           wait_target;
    logic             last_elem;

    assign last_elem = (elem_idx_reg == len_reg - LEN_W'(1));

    always_comb begin
        wait_done   = 1'b0;
        wait_target = IDLE;
        case (state_reg)
            FETCH_WAIT: begin
                wait_done   = bus.fetch_done;
                wait_target = last_elem ? COMP_REQ : FETCH_REQ;
            end
            COMP_WAIT: begin
                wait_done   = bus.processing_done;
                wait_target = WR_REQ;
            end
            WR_WAIT: begin
                wait_done   = bus.store_done;
                wait_target = RD_REQ;
            end
            RD_WAIT: begin
                wait_done   = bus.read_done;
                wait_target = DONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        base_a_next   = base_a_reg;
        base_b_next   = base_b_reg;
        base_out_next = base_out_reg;
        elem_idx_next = elem_idx_reg;
        error_next    = error_reg;
        // The counter restarts from zero whenever the FSM is not waiting,
        // so each WAIT state begins with a fresh count.
        tmo_next      = '0;

        if (state_reg != IDLE && bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.go) begin
                        len_next      = bus.vec_len;
                        base_a_next   = bus.base_a;
                        base_b_next   = bus.base_b;
                        base_out_next = bus.base_out;
                        elem_idx_next = '0;
                        error_next    = 1'b0;
                        state_next    = (bus.vec_len == '0) ? DONE : FETCH_REQ;
                    end
                end
                FETCH_REQ: state_next = FETCH_WAIT;
                COMP_REQ:  state_next = COMP_WAIT;
                WR_REQ:    state_next = WR_WAIT;
                RD_REQ:    state_next = RD_WAIT;
                FETCH_WAIT, COMP_WAIT, WR_WAIT, RD_WAIT: begin
                    // A done arriving on the expiry cycle still wins.
                    if (wait_done) begin
                        state_next = wait_target;
                        if (state_reg == FETCH_WAIT && !last_elem) begin
                            elem_idx_next = elem_idx_reg + LEN_W'(1);
                        end
                    end else if (tmo_reg == TMO_LAST) begin
                        state_next = ERR;
                        error_next = 1'b1;
                    end else begin
                        tmo_next = tmo_reg + CNT_W'(1);
                    end
                end
                DONE:    state_next = IDLE;
                ERR:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state values so that they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            len_reg           <= '0;
            base_a_reg        <= '0;
            base_b_reg        <= '0;
            base_out_reg      <= '0;
            elem_idx_reg      <= '0;
            tmo_reg           <= '0;
            error_reg         <= 1'b0;
            start_fetch_reg   <= 1'b0;
            start_compute_reg <= 1'b0;
            start_write_reg   <= 1'b0;
            start_read_reg    <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            waddr_a_reg       <= '0;
            waddr_b_reg       <= '0;
            waddr_output_reg  <= '0;
        end else begin
            state_reg         <= state_next;
            len_reg           <= len_next;
            base_a_reg        <= base_a_next;
            base_b_reg        <= base_b_next;
            base_out_reg      <= base_out_next;
            elem_idx_reg      <= elem_idx_next;
            tmo_reg           <= tmo_next;
            error_reg         <= error_next;
            start_fetch_reg   <= (state_next == FETCH_REQ);
            start_compute_reg <= (state_next == COMP_REQ);
            start_write_reg   <= (state_next == WR_REQ);
            start_read_reg    <= (state_next == RD_REQ);
            busy_reg          <= (state_next != IDLE);
            done_reg          <= (state_next == DONE);
            waddr_a_reg       <= base_a_next + 32'(elem_idx_next);
            waddr_b_reg       <= base_b_next + 32'(elem_idx_next);
            waddr_output_reg  <= base_out_next;
        end
    end

    assign bus.start_fetch   = start_fetch_reg;
    assign bus.start_compute = start_compute_reg;
    assign bus.start_write   = start_write_reg;
    assign bus.start_read    = start_read_reg;
    assign bus.waddr_a       = waddr_a_reg;
    assign bus.waddr_b       = waddr_b_reg;
    assign bus.waddr_output  = waddr_output_reg;
    assign bus.elem_idx      = elem_idx_reg;
    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.error         = error_reg;
endmodule
